tx_serial_n: RTL and testbench

Parametrised asynchronous serial transmitter: accepts one character word per request and shifts it out as a complete framed line (start bit, LSB-first data, optional parity, one or two stop bits), each bit held for a programmable number of clock cycles. Successor of the fixed 7-bit ASCII transmit datapath. Contains its own control FSM and baud tick counter, so upper-level designs drive it with a single `partida` pulse and watch `pronto`. Sits between the character source (keyboard/ROM/FSM) and the serial output pin.

---
 rtl/tx_serial_pkg.sv | 26 ++
 rtl/tx_serial_n_contador_tick.sv | 26 ++
 rtl/tx_serial_n.sv | 170 +++++++++++++++++
 tb/tb_tx_serial_n.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_serial_pkg.sv
// Shared definitions for the framed serial transmitter: parity modes, FSM states
// and the parity helper used when a word is latched.
package tx_serial_pkg;

  localparam logic [1:0] PAR_NENHUMA = 2'd0;
  localparam logic [1:0] PAR_IMPAR   = 2'd1;
  localparam logic [1:0] PAR_PAR     = 2'd2;

  typedef enum logic [2:0] {
    REPOUSO,
    INICIO,
    DADOS,
    PARIDADE,
    PARADA
  } estado_t;

  // Zero-extended words keep the XOR reduction exact for any width up to 9 bits.
  function automatic logic calc_paridade(input logic [1:0] modo, input logic [8:0] palavra);
    case (modo)
      PAR_IMPAR: return ~^palavra;
      PAR_PAR:   return ^palavra;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tx_serial_n_contador_tick.sv
// Modulo-N bit-time counter with synchronous clear and a terminal-count flag
// that marks the last cycle of each bit.
module contador_tick #(
  parameter int N = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tc
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] ULTIMO = W'(N - 1);

  logic [W-1:0] contagem;

  // NOTE: sequential state is always written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear || tc) contagem <= '0;
    else                      contagem <= contagem + W'(1);
  end

  assign tc = (contagem == ULTIMO);

endmodule

// File: rtl/tx_serial_n.sv
// Framed asynchronous serial transmitter (start, LSB-first data, parity, stop bits).
// Define TX_SERIAL_BUFFER_EN for a one-word holding register and gapless frames.
module tx_serial_n
  import tx_serial_pkg::*;
#(
  parameter int DATA_BITS     = 7,
  parameter int PARITY        = 2,
  parameter int STOP_BITS     = 2,
  parameter int TICKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 partida,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 saida_serial,
  output logic                 aceita,
  output logic                 ocupado,
  output logic                 pronto
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] ULT_DADO   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] ULT_PARADA = BW'(STOP_BITS - 1);
  localparam logic [1:0]    MODO       = 2'(PARITY);

  estado_t              estado, prox;
  logic [DATA_BITS-1:0] desloc, desloc_d;
  logic [BW-1:0]        n_bit, n_bit_d;
  logic                 par_q, par_d;
  logic                 linha_d, pronto_d;
  logic                 tc, limpa, aceito;

`ifdef TX_SERIAL_BUFFER_EN
  logic                 buf_valido, buf_valido_d;
  logic [DATA_BITS-1:0] buf_dado, buf_dado_d;

  assign aceita = ~buf_valido;
`else
  assign aceita = (estado == REPOUSO);
`endif

  assign ocupado = (estado != REPOUSO);
  assign aceito  = partida & aceita;
  assign limpa   = (prox != estado);

  contador_tick #(.N(TICKS_PER_BIT)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (limpa),
    .tc    (tc)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    prox     = estado;
    desloc_d = desloc;
    n_bit_d  = n_bit;
    par_d    = par_q;
    linha_d  = saida_serial;
    pronto_d = 1'b0;
`ifdef TX_SERIAL_BUFFER_EN
    buf_valido_d = buf_valido;
    buf_dado_d   = buf_dado;
    if (aceito && estado != REPOUSO) begin
      buf_valido_d = 1'b1;
      buf_dado_d   = dados;
    end
`endif

    case (estado)
      REPOUSO: begin
        if (aceito) begin
          prox     = INICIO;
          desloc_d = dados;
          par_d    = calc_paridade(MODO, 9'(dados));
          linha_d  = 1'b0;
        end
      end
      INICIO: begin
        if (tc) begin
          prox    = DADOS;
          n_bit_d = '0;
          linha_d = desloc[0];
        end
      end
      DADOS: begin
        if (tc) begin
          if (n_bit == ULT_DADO) begin
            n_bit_d = '0;
            if (MODO != PAR_NENHUMA) begin
              prox    = PARIDADE;
              linha_d = par_q;
            end else begin
              prox    = PARADA;
              linha_d = 1'b1;
            end
          end else begin
            desloc_d = desloc >> 1;
            linha_d  = desloc[1];
            n_bit_d  = n_bit + BW'(1);
          end
        end
      end
      PARIDADE: begin
        if (tc) begin
          prox    = PARADA;
          n_bit_d = '0;
          linha_d = 1'b1;
        end
      end
      PARADA: begin
        if (tc) begin
          if (n_bit == ULT_PARADA) begin
            pronto_d = 1'b1;
            n_bit_d  = '0;
            prox     = REPOUSO;
            linha_d  = 1'b1;
`ifdef TX_SERIAL_BUFFER_EN
            // A held word (or one offered on this very cycle) starts with no idle gap.
            if (buf_valido) begin
              prox         = INICIO;
              desloc_d     = buf_dado;
              par_d        = calc_paridade(MODO, 9'(buf_dado));
              linha_d      = 1'b0;
              buf_valido_d = 1'b0;
            end else if (aceito) begin
              prox         = INICIO;
              desloc_d     = dados;
              par_d        = calc_paridade(MODO, 9'(dados));
              linha_d      = 1'b0;
              buf_valido_d = 1'b0;
            end
`endif
          end else begin
            n_bit_d = n_bit + BW'(1);
          end
        end
      end
      default: prox = REPOUSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= REPOUSO;
      desloc       <= '0;
      n_bit        <= '0;
      par_q        <= 1'b0;
      saida_serial <= 1'b1;
      pronto       <= 1'b0;
`ifdef TX_SERIAL_BUFFER_EN
      buf_valido   <= 1'b0;
      buf_dado     <= '0;
`endif
    end else begin
      estado       <= prox;
      desloc       <= desloc_d;
      n_bit        <= n_bit_d;
      par_q        <= par_d;
      saida_serial <= linha_d;
      pronto       <= pronto_d;
`ifdef TX_SERIAL_BUFFER_EN
      buf_valido   <= buf_valido_d;
      buf_dado     <= buf_dado_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_serial_n.sv
// Self-checking bench for tx_serial_n: three parameter sets, per-cycle scoreboard of
// line/pronto/ocupado, latency, ignored-request, reset and (if enabled) buffer cases.
module tb_tx_serial_n;

  typedef struct packed {
    logic linha;
    logic pronto;
    logic ocupado;
  } esperado_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       partida = 1'b0;
  logic [7:0] dados = 8'h00;
  logic [1:0] sel = 2'd0;

  logic [2:0] partida_v, linha_v, aceita_v, ocupado_v, pronto_v;
  logic       obs_linha, obs_aceita, obs_ocupado, obs_pronto;

  assign partida_v[0] = partida & (sel == 2'd0);
  assign partida_v[1] = partida & (sel == 2'd1);
  assign partida_v[2] = partida & (sel == 2'd2);

  assign obs_linha   = linha_v[sel];
  assign obs_aceita  = aceita_v[sel];
  assign obs_ocupado = ocupado_v[sel];
  assign obs_pronto  = pronto_v[sel];

  // 7 data, even, 2 stop
  tx_serial_n #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .TICKS_PER_BIT(4)) u_dut0 (
    .clock(clock), .reset(reset), .partida(partida_v[0]), .dados(dados[6:0]),
    .saida_serial(linha_v[0]), .aceita(aceita_v[0]), .ocupado(ocupado_v[0]), .pronto(pronto_v[0]));

  // 7 data, odd, 2 stop
  tx_serial_n #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .TICKS_PER_BIT(4)) u_dut1 (
    .clock(clock), .reset(reset), .partida(partida_v[1]), .dados(dados[6:0]),
    .saida_serial(linha_v[1]), .aceita(aceita_v[1]), .ocupado(ocupado_v[1]), .pronto(pronto_v[1]));

  // 8 data, no parity, 1 stop
  tx_serial_n #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .TICKS_PER_BIT(4)) u_dut2 (
    .clock(clock), .reset(reset), .partida(partida_v[2]), .dados(dados),
    .saida_serial(linha_v[2]), .aceita(aceita_v[2]), .ocupado(ocupado_v[2]), .pronto(pronto_v[2]));

  always #5 clock = ~clock;

  esperado_t exp_q[$];
  int        pronto_cyc[$];
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        t_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare the cycle's outputs against the scoreboard head.
  task automatic step();
    esperado_t e;
    @(negedge clock);
    cyc++;
    if (obs_pronto === 1'b1) pronto_cyc.push_back(cyc);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '{linha: 1'b1, pronto: 1'b0, ocupado: 1'b0};
    check($sformatf("linha@%0d", cyc),   32'(obs_linha),   32'(e.linha));
    check($sformatf("pronto@%0d", cyc),  32'(obs_pronto),  32'(e.pronto));
    check($sformatf("ocupado@%0d", cyc), 32'(obs_ocupado), 32'(e.ocupado));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Independent frame model: start, LSB-first data, parity, stop bits, 4 cycles each.
  function automatic void push_frame(input int cfg, input logic [7:0] d, input bit merge);
    int   nb, par, st;
    logic p;
    logic b[$];
    bit   primeiro;
    case (cfg)
      0:       begin nb = 7; par = 2; st = 2; end
      1:       begin nb = 7; par = 1; st = 2; end
      default: begin nb = 8; par = 0; st = 1; end
    endcase
    p = 1'b0;
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      b.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par == 1) b.push_back(~p);
    if (par == 2) b.push_back(p);
    for (int i = 0; i < st; i++) b.push_back(1'b1);
    if (merge) void'(exp_q.pop_back());
    primeiro = merge;
    foreach (b[i]) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back('{linha: b[i], pronto: primeiro, ocupado: 1'b1});
        primeiro = 1'b0;
      end
    end
    exp_q.push_back('{linha: 1'b1, pronto: 1'b1, ocupado: 1'b0});
  endfunction

  task automatic start(input int cfg, input logic [7:0] d);
    check($sformatf("aceita_start@%0d", cyc), 32'(obs_aceita), 32'd1);
    partida = 1'b1;
    dados   = d;
    t_acc   = cyc;
    push_frame(cfg, d, 1'b0);
    step();
    partida = 1'b0;
  endtask

  task automatic check_lat(input string tag, input int lat);
    check({tag, "_n_pronto"}, 32'(pronto_cyc.size()), 32'd1);
    check({tag, "_lat"}, (pronto_cyc.size() > 0) ? 32'(pronto_cyc[0] - t_acc) : 32'hFFFF_FFFF,
          32'(lat));
    pronto_cyc.delete();
  endtask

  initial begin
    // Reset state
    run(3);
    check("reset_aceita", 32'(obs_aceita), 32'd1);
    reset = 1'b0;
    run(2);

    // 7 data, even parity, 2 stop: 'A'
    sel = 2'd0;
    start(0, 8'h41);
    run(44);
    check_lat("t1_even", 45);
    check("t1_aceita_in_pronto", 32'(obs_aceita), 32'd1);

    // Request accepted in the pronto cycle: start bit one cycle later
    start(0, 8'h2C);
    run(44);
    check_lat("t1b_back", 45);
    run(2);

    // Odd parity
    sel = 2'd1;
    run(1);
    start(1, 8'h41);
    run(44);
    check_lat("t2_odd", 45);
    run(2);

    // 8 data, no parity, 1 stop
    sel = 2'd2;
    run(1);
    start(2, 8'hA5);
    run(40);
    check_lat("t3_8n1", 41);
    run(2);

    sel = 2'd0;
    run(1);
`ifndef TX_SERIAL_BUFFER_EN
    // Request while busy is ignored
    start(0, 8'h41);
    run(9);
    check("t4_aceita_busy", 32'(obs_aceita), 32'd0);
    partida = 1'b1;
    dados   = 8'h7F;
    step();
    partida = 1'b0;
    run(34);
    run(5);
    check_lat("t4_ignore", 45);
`endif

    // Reset mid-frame
    start(0, 8'h41);
    run(16);
    reset = 1'b1;
    exp_q.delete();
    step();
    check("t5_aceita_after_reset", 32'(obs_aceita), 32'd1);
    reset = 1'b0;
    run(3);
    check("t5_no_pronto", 32'(pronto_cyc.size()), 32'd0);
    pronto_cyc.delete();
    start(0, 8'h41);
    run(44);
    check_lat("t5_after_reset", 45);
    run(2);

`ifdef TX_SERIAL_BUFFER_EN
    // Buffered back-to-back frames
    start(0, 8'h41);
    run(4);
    check("t6_aceita_buf_empty", 32'(obs_aceita), 32'd1);
    partida = 1'b1;
    dados   = 8'h42;
    push_frame(0, 8'h42, 1'b1);
    step();
    partida = 1'b0;
    check("t6_aceita_buf_full", 32'(obs_aceita), 32'd0);
    run(83);
    run(2);
    check("t6_n_pronto", 32'(pronto_cyc.size()), 32'd2);
    check("t6_first_lat", (pronto_cyc.size() > 0) ? 32'(pronto_cyc[0] - t_acc) : 32'hFFFF_FFFF,
          32'd45);
    check("t6_spacing", (pronto_cyc.size() > 1) ? 32'(pronto_cyc[1] - pronto_cyc[0]) : 32'hFFFF_FFFF,
          32'd44);
    pronto_cyc.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
